// File: rtl/mycpu_pkg.sv
// Shared CPU types: memory-op encoding, memory-stage FSM states and op-decoding helpers.
package mycpu_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        LB       = 4'd1,
        LBU      = 4'd2,
        LH       = 4'd3,
        LHU      = 4'd4,
        LW       = 4'd5,
        LWU      = 4'd6,
        LD       = 4'd7,
        SB       = 4'd8,
        SH       = 4'd9,
        SW       = 4'd10,
        SD       = 4'd11
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

    // Unknown encodings and doubleword ops on a narrow bus collapse to MOP_NONE.
    function automatic mem_op_t decode_op(input logic [3:0] raw, input logic wide);
        mem_op_t op;
        op = (raw > 4'd11) ? MOP_NONE : mem_op_t'(raw);
        if (!wide && (op == LD || op == SD)) op = MOP_NONE;
        return op;
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, LWU, LD};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {SB, SH, SW, SD};
    endfunction

    function automatic logic [1:0] size_log2(input mem_op_t op);
        case (op)
            LH, LHU, SH: return 2'd1;
            LW, LWU, SW: return 2'd2;
            LD, SD:      return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] size_mask(input mem_op_t op);
        return 3'((4'd1 << size_log2(op)) - 4'd1);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and sign/zero-extends it.
module mem_load_align
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata,
    input  logic [$clog2(DATA_W/8)-1:0]  lane,
    input  logic [3:0]                   mem_op,
    output logic [DATA_W-1:0]            ld_data
);

    logic [DATA_W-1:0] shifted;
    mem_op_t           op;

    assign op      = mem_op_t'(mem_op);
    assign shifted = rdata >> {lane, 3'b000};

    // NOTE: ld_data gets a value on every path (default arm) so no latch is inferred.
    always_comb begin
        case (op)
            LB:      ld_data = DATA_W'($signed(shifted[7:0]));
            LBU:     ld_data = DATA_W'(shifted[7:0]);
            LH:      ld_data = DATA_W'($signed(shifted[15:0]));
            LHU:     ld_data = DATA_W'(shifted[15:0]);
            LW:      ld_data = DATA_W'($signed(shifted[31:0]));
            LWU:     ld_data = DATA_W'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage: one outstanding data-memory request, load alignment, WB handshake.
// Define MEM_MISALIGN_EXC_EN to trap misaligned accesses through wb_exc instead of aligning them.
module mem_access_stage
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_to_mem_valid,
    output logic                mem_allow_in,
    input  logic [ADDR_W-1:0]   ex_pc,
    input  logic [DATA_W-1:0]   ex_alu_result,
    input  logic [DATA_W-1:0]   ex_st_data,
    input  logic [3:0]          ex_mem_op,
    input  logic                ex_rf_we,
    input  logic [RF_AW-1:0]    ex_rf_waddr,
    output logic                dram_req,
    output logic                dram_wr,
    output logic [ADDR_W-1:0]   dram_addr,
    output logic [DATA_W/8-1:0] dram_wstrb,
    output logic [DATA_W-1:0]   dram_wdata,
    input  logic                dram_addr_ok,
    input  logic                dram_data_ok,
    input  logic [DATA_W-1:0]   dram_rdata,
    input  logic                wb_allow_in,
    output logic                mem_to_wb_valid,
    output logic [ADDR_W-1:0]   wb_pc,
    output logic                wb_rf_we,
    output logic [RF_AW-1:0]    wb_rf_waddr,
`ifdef MEM_MISALIGN_EXC_EN
    output logic                wb_exc,
`endif
    output logic [DATA_W-1:0]   wb_rf_wdata
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);

    mem_state_t        state;
    logic              valid;
    logic              ready_go;
    logic              accept_in;
    logic              start_mem;
    logic              ex_exc;
    mem_op_t           ex_op;

    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] st_q;
    logic [DATA_W-1:0] hold_q;
    mem_op_t           op_q;
    logic              rf_we_q;
    logic [RF_AW-1:0]  waddr_q;
    logic              exc_q;

    logic [1:0]        sz;
    logic [ADDR_W-1:0] req_addr;
    logic [LANE_W-1:0] lane;
    logic [NBYTES-1:0] strb_base;
    logic [DATA_W-1:0] load_data;

    assign ex_op = decode_op(ex_mem_op, DATA_W == 64);

`ifdef MEM_MISALIGN_EXC_EN
    assign ex_exc = (ex_op != MOP_NONE) && |(ex_alu_result[2:0] & size_mask(ex_op));
    assign wb_exc = valid & exc_q;
`else
    assign ex_exc = 1'b0;
`endif

    assign accept_in = ex_to_mem_valid & mem_allow_in;
    assign start_mem = (ex_op != MOP_NONE) & ~ex_exc;

    always_comb begin
        case (state)
            IDLE:    ready_go = valid;
            WAIT:    ready_go = dram_data_ok;
            HOLD:    ready_go = 1'b1;
            default: ready_go = 1'b0;
        endcase
    end

    assign mem_allow_in    = ~valid | (ready_go & wb_allow_in);
    assign mem_to_wb_valid = valid & ready_go;

    // Request side: low address bits below the access size are dropped.
    assign sz        = size_log2(op_q);
    assign req_addr  = ADDR_W'(alu_q) & ~ADDR_W'(size_mask(op_q));
    assign lane      = req_addr[LANE_W-1:0];
    assign strb_base = NBYTES'((16'd1 << (4'd1 << sz)) - 16'd1);

    assign dram_req   = (state == REQ);
    assign dram_wr    = is_store(op_q);
    assign dram_addr  = req_addr;
    assign dram_wstrb = is_store(op_q) ? (strb_base << lane) : '0;

    always_comb begin
        dram_wdata = '0;
        for (int i = 0; i < NBYTES; i++)
            dram_wdata[i*8 +: 8] = st_q[(i % (1 << sz)) * 8 +: 8];
    end

    mem_load_align #(.DATA_W(DATA_W)) u_load_align (
        .rdata   (dram_rdata),
        .lane    (lane),
        .mem_op  (op_q),
        .ld_data (load_data)
    );

    assign wb_pc       = pc_q;
    assign wb_rf_waddr = waddr_q;
    assign wb_rf_we    = valid & rf_we_q & ~is_store(op_q) & ~exc_q;

    always_comb begin
        case (state)
            WAIT:    wb_rf_wdata = load_data;
            HOLD:    wb_rf_wdata = hold_q;
            default: wb_rf_wdata = alu_q;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            valid   <= 1'b0;
            pc_q    <= '0;
            alu_q   <= '0;
            st_q    <= '0;
            hold_q  <= '0;
            op_q    <= MOP_NONE;
            rf_we_q <= 1'b0;
            waddr_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            if (mem_allow_in) valid <= ex_to_mem_valid;

            if (accept_in) begin
                pc_q    <= ex_pc;
                alu_q   <= ex_alu_result;
                st_q    <= ex_st_data;
                op_q    <= ex_op;
                rf_we_q <= ex_rf_we;
                waddr_q <= ex_rf_waddr;
                exc_q   <= ex_exc;
            end

            if (state == WAIT && dram_data_ok && !wb_allow_in) hold_q <= load_data;

            // Leaving WAIT/HOLD with a WB transfer may issue the next request immediately.
            if (state == REQ) begin
                if (dram_addr_ok) state <= WAIT;
            end else if (state == WAIT && dram_data_ok && !wb_allow_in) begin
                state <= HOLD;
            end else if (mem_allow_in) begin
                state <= (accept_in && start_mem) ? REQ : IDLE;
            end
        end
    end

endmodule
